// File: rtl/l1_miss_handler_if.sv
// Handshake bundle between the L1, the miss handler and next-level memory.
// The master modport is the miss handler's view; slave is the L1/memory side.
interface l1_miss_handler_if #(
    parameter int WORD_SIZE = 32
);
    logic                 miss_valid;
    logic                 miss_ready;
    logic [WORD_SIZE-1:0] miss_addr;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [WORD_SIZE-1:0] mem_req_addr;

    logic                 mem_resp_valid;
    logic [WORD_SIZE-1:0] mem_resp_data;
    logic                 mem_resp_err;

    logic                 fill_valid;
    logic                 fill_ready;
    logic [WORD_SIZE-1:0] fill_addr;
    logic [WORD_SIZE-1:0] fill_data;
    logic                 fill_err;

    modport master (
        input  miss_valid, miss_addr, mem_req_ready,
        input  mem_resp_valid, mem_resp_data, mem_resp_err, fill_ready,
        output miss_ready, mem_req_valid, mem_req_addr,
        output fill_valid, fill_addr, fill_data, fill_err
    );

    modport slave (
        output miss_valid, miss_addr, mem_req_ready,
        output mem_resp_valid, mem_resp_data, mem_resp_err, fill_ready,
        input  miss_ready, mem_req_valid, mem_req_addr,
        input  fill_valid, fill_addr, fill_data, fill_err
    );
endinterface

// File: rtl/l1_miss_handler.sv
// Single-entry L1 miss handler: one word read to memory per miss, watchdog-bounded wait,
// result returned as a fill beat. Optional L1_MISS_STATS_EN adds miss/timeout counters.
module l1_miss_handler #(
    parameter int WORD_SIZE      = 32,
    parameter int TAG_SIZE       = 28,
    parameter int INDEX_SIZE     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    l1_miss_handler_if.master    bus,
    output logic                 busy
`ifdef L1_MISS_STATS_EN
    ,
    output logic [15:0]          miss_count,
    output logic [15:0]          timeout_count
`endif
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end
    if ((2 ** CNT_WIDTH) <= TIMEOUT_CYCLES) begin : g_bad_cnt
        $error("CNT_WIDTH too small for TIMEOUT_CYCLES");
    end
    if (TAG_SIZE + INDEX_SIZE > WORD_SIZE) begin : g_bad_split
        $error("TAG_SIZE + INDEX_SIZE exceeds WORD_SIZE");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]   data_q, data_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.miss_valid) begin
                    addr_d  = bus.miss_addr;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response arriving on the expiry cycle takes priority over the timeout.
                if (bus.mem_resp_valid) begin
                    data_d  = bus.mem_resp_data;
                    err_d   = bus.mem_resp_err;
                    state_d = S_FILL;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.fill_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.miss_ready    = (state_q == S_IDLE);
    assign bus.mem_req_valid = (state_q == S_REQ);
    assign bus.mem_req_addr  = addr_q;
    assign bus.fill_valid    = (state_q == S_FILL);
    assign bus.fill_addr     = addr_q;
    assign bus.fill_data     = data_q;
    assign bus.fill_err      = err_q;
    assign busy              = (state_q != S_IDLE);

`ifdef L1_MISS_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        accept_w;
    logic        timeout_w;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;

    assign accept_w  = (state_q == S_IDLE) && bus.miss_valid;
    assign timeout_w = (state_q == S_WAIT) && !bus.mem_resp_valid && (cnt_q == CNT_LAST);

    always_comb begin
        miss_cnt_d = accept_w  ? sat_inc(miss_cnt_q) : miss_cnt_q;
        to_cnt_d   = timeout_w ? sat_inc(to_cnt_q)   : to_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign miss_count    = miss_cnt_q;
    assign timeout_count = to_cnt_q;
`endif

endmodule
